// File: rtl/dti_pkg.sv
// Shared phase-state type and default sizing for the three-phase dead-time inserter.
package dti_pkg;

    typedef enum logic [1:0] {
        DEAD  = 2'd0,
        HI_ON = 2'd1,
        LO_ON = 2'd2
    } phase_state_t;

    localparam int DEF_CNT_W       = 32'sd8;
    localparam int DEF_DEAD_CYCLES = 32'sd25;

endpackage

// File: rtl/dti_phase.sv
// One inverter leg: registered command, DEAD/HI_ON/LO_ON FSM with dead-time counter,
// and registered complementary gate outputs.
module dti_phase
    import dti_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic cmd,
    output logic gate_hi,
    output logic gate_lo
);

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DEAD_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'sd1);

    logic             cmd_r;
    phase_state_t     state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             hi_r;
    logic             lo_r;

    // Command sample register; the FSM only ever looks at this copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r <= 1'b0;
        end else begin
            cmd_r <= cmd;
        end
    end

    // Leg FSM; gates are decoded into flops together with the state so hi and lo never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DEAD;
            cnt_r   <= CNT_RELOAD;
            hi_r    <= 1'b0;
            lo_r    <= 1'b0;
        end else if (!run) begin
            state_r <= DEAD;
            cnt_r   <= CNT_RELOAD;
            hi_r    <= 1'b0;
            lo_r    <= 1'b0;
        end else begin
            case (state_r)
                HI_ON: begin
                    if (!cmd_r) begin
                        state_r <= DEAD;
                        cnt_r   <= CNT_RELOAD;
                        hi_r    <= 1'b0;
                        lo_r    <= 1'b0;
                    end else begin
                        hi_r    <= 1'b1;
                        lo_r    <= 1'b0;
                    end
                end
                LO_ON: begin
                    if (cmd_r) begin
                        state_r <= DEAD;
                        cnt_r   <= CNT_RELOAD;
                        hi_r    <= 1'b0;
                        lo_r    <= 1'b0;
                    end else begin
                        hi_r    <= 1'b0;
                        lo_r    <= 1'b1;
                    end
                end
                DEAD: begin
                    // Target leg is chosen only at expiry; command activity never restarts the count.
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= cmd_r ? HI_ON : LO_ON;
                        hi_r    <= cmd_r;
                        lo_r    <= ~cmd_r;
                    end else begin
                        cnt_r   <= cnt_r - CNT_ONE;
                        hi_r    <= 1'b0;
                        lo_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= DEAD;
                    cnt_r   <= CNT_RELOAD;
                    hi_r    <= 1'b0;
                    lo_r    <= 1'b0;
                end
            endcase
        end
    end

    assign gate_hi = hi_r;
    assign gate_lo = lo_r;

endmodule

// File: rtl/deadtime_inserter.sv
// Three-phase dead-time insertion stage with run gating and an optional latched external
// fault (enabled by defining DEADTIME_FAULT_LATCH_EN).
module deadtime_inserter
    import dti_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic Va,
    input  logic Vb,
    input  logic Vc,
    input  logic fault_n,
    input  logic fault_clr,
    output logic Ga_hi,
    output logic Ga_lo,
    output logic Gb_hi,
    output logic Gb_lo,
    output logic Gc_hi,
    output logic Gc_lo,
    output logic fault_flag
);

    if ((DEAD_CYCLES < 32'sd1) || (DEAD_CYCLES > ((32'sd1 <<< CNT_W) - 32'sd1))) begin : g_param_check
        $error("deadtime_inserter: DEAD_CYCLES outside 1..2**CNT_W-1");
    end

    logic fault_block_s;
    logic run_s;
    logic run_r;

`ifdef DEADTIME_FAULT_LATCH_EN
    logic fault_meta_r;
    logic fault_sync_r;
    logic fault_flag_r;

    // Fault synchronizer and latch; an active synchronized fault always beats fault_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fault_meta_r <= 1'b1;
            fault_sync_r <= 1'b1;
            fault_flag_r <= 1'b0;
        end else begin
            fault_meta_r <= fault_n;
            fault_sync_r <= fault_meta_r;
            if (!fault_sync_r) begin
                fault_flag_r <= 1'b1;
            end else if (fault_clr) begin
                fault_flag_r <= 1'b0;
            end else begin
                fault_flag_r <= fault_flag_r;
            end
        end
    end

    // Block on the synchronized fault itself too, so gating starts a cycle before the flag shows.
    assign fault_block_s = fault_flag_r | ~fault_sync_r;
    assign fault_flag    = fault_flag_r;
`else
    logic unused_fault_s;
    assign unused_fault_s = fault_n ^ fault_clr;
    assign fault_block_s  = 1'b0;
    assign fault_flag     = 1'b0;
`endif

    // Combine run enable with fault blocking.
    always_comb begin
        run_s = 1'b0;
        if (enable && !fault_block_s) begin
            run_s = 1'b1;
        end else begin
            run_s = 1'b0;
        end
    end

    // Run qualifier is registered so it lines up with the registered commands in each leg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_r <= 1'b0;
        end else begin
            run_r <= run_s;
        end
    end

    dti_phase #(.CNT_W(CNT_W), .DEAD_CYCLES(DEAD_CYCLES)) u_phase_a (
        .clk(clk), .rst_n(reset), .run(run_r), .cmd(Va), .gate_hi(Ga_hi), .gate_lo(Ga_lo)
    );

    dti_phase #(.CNT_W(CNT_W), .DEAD_CYCLES(DEAD_CYCLES)) u_phase_b (
        .clk(clk), .rst_n(reset), .run(run_r), .cmd(Vb), .gate_hi(Gb_hi), .gate_lo(Gb_lo)
    );

    dti_phase #(.CNT_W(CNT_W), .DEAD_CYCLES(DEAD_CYCLES)) u_phase_c (
        .clk(clk), .rst_n(reset), .run(run_r), .cmd(Vc), .gate_hi(Gc_hi), .gate_lo(Gc_lo)
    );

endmodule

// File: doc/deadtime_inserter.md
# deadtime_inserter

Three-phase dead-time insertion stage that sits directly downstream of the SPWM comparator stage. It consumes the per-phase PWM commands Va, Vb and Vc, and drives complementary high-side/low-side gate signals. Each phase has a guaranteed interval of DEAD_CYCLES clocks with both switches off around every transition. The outputs feed the inverter gate drivers, so shoot-through must be impossible under every input sequence, including reset and fault.

## Interface

**Parameters**
- CNT_W, 8: dead-time counter width.
- DEAD_CYCLES, 25: both-off interval in clk cycles. Legal range is 1 ≤ DEAD_CYCLES ≤ 2**CNT_W−1; elaboration fails outside it.

**Ports**
- clk, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: run enable. When 0, all gates are forced off.
- Va, input, 1: phase A PWM command (1 = high side on).
- Vb, input, 1: phase B PWM command.
- Vc, input, 1: phase C PWM command.
- fault_n, input, 1: active-low external fault. Used only with the fault-latch feature.
- fault_clr, input, 1: clears the latched fault. Used only with the fault-latch feature.
- Ga_hi, output, 1: phase A high-side gate.
- Ga_lo, output, 1: phase A low-side gate.
- Gb_hi, output, 1: phase B high-side gate.
- Gb_lo, output, 1: phase B low-side gate.
- Gc_hi, output, 1: phase C high-side gate.
- Gc_lo, output, 1: phase C low-side gate.
- fault_flag, output, 1: fault latched.

## Operation

- **Command register:** each Vx is registered once into cmd_q. The FSM acts only on cmd_q.
- **Per-phase FSM states:**
  - DEAD: hi=0, lo=0, counter running.
  - HI_ON: hi=1, lo=0.
  - LO_ON: hi=0, lo=1.
- **Reset:**
  - Every FSM enters DEAD with counter = DEAD_CYCLES−1.
  - All six gates are 0 and fault_flag is 0.
- **HI_ON:**
  - If cmd_q=0, go to DEAD and load the counter to DEAD_CYCLES−1.
  - Otherwise stay.
- **LO_ON:**
  - If cmd_q=1, go to DEAD and load the counter to DEAD_CYCLES−1.
  - Otherwise stay.
- **DEAD:**
  - Decrement the counter each cycle.
  - When counter==0, go to HI_ON if cmd_q=1, else LO_ON.
  - The target is sampled at expiry only. A cmd_q toggle during DEAD never restarts or shortens the count.
  - Short command pulses (shorter than DEAD_CYCLES) may therefore be swallowed or stretched. The dead time is always honoured.
- **Invariant:** hi & lo == 0 on every cycle in every phase. All gates are registered outputs with no combinational path from any input.
- **enable=0:**
  - Every FSM goes to DEAD with the counter reloaded; gates go low on the next edge.
  - While enable=0, the FSMs stay in DEAD and the counter is held at reload.
  - After enable rises, a full DEAD_CYCLES interval elapses before any gate asserts.
- **Phases are independent:** there is no cross-phase interlock.

## Timing

- **Command-change latency:**
  - Vx changes before edge k; cmd_q updates at edge k.
  - The active gate drops at edge k+1.
  - The opposite gate rises at edge k+1+DEAD_CYCLES.
  - Both-off time is exactly DEAD_CYCLES cycles.
- **Reset release:** the first gate asserts DEAD_CYCLES edges after the first enabled edge following reset deassertion.
- **Asynchronous reset assertion:** gates drop immediately, mid-operation included, without waiting for a clock edge.
- **enable falling at edge k:** gates are low after edge k+1.
- **Counter arithmetic:** unsigned CNT_W bits, decrement only. The counter never wraps because it is reloaded before it can underflow.

## Configuration

- **Macro DEADTIME_FAULT_LATCH_EN defined:**
  - fault_n is passed through a 2-flop synchronizer.
  - A synchronized 0 sets fault_flag. While fault_flag=1, behaviour is identical to enable=0 (all gates off, FSMs held in DEAD).
  - fault_flag clears only on reset, or on fault_clr=1 while the synchronized fault_n=1.
  - If fault_clr and an active fault coincide, the fault wins.
- **Macro not defined:**
  - fault_n and fault_clr are ignored.
  - fault_flag is tied to 0.
  - No synchronizer flops are instantiated.

## Structure

- **Package dti_pkg** holds:
  - the phase state typedef (DEAD, HI_ON, LO_ON);
  - the default CNT_W;
  - the default DEAD_CYCLES.
- **Sub-module dti_phase** covers one phase (cmd register, FSM, counter, gate registers). It is instantiated three times.
- **Top level** contains the three dti_phase instances, the enable/fault gating and the optional fault latch.

## Test plan

- **Reset release:** reset low, then high with enable=1 and Va=1 → Ga_hi rises exactly 25 edges after the first enabled edge; Ga_lo stays 0.
- **Steady square wave:** Va square wave with 200-cycle period → both Ga gates low for exactly 25 cycles around every edge; Ga_hi & Ga_lo never 1.
- **Short pulse:** Vb 0→1→0 with a 10-cycle high pulse while in LO_ON → Gb_lo low for exactly 25 cycles, then Gb_lo returns; Gb_hi never asserts.
- **Enable drop and restore:** enable dropped mid-HI_ON → all gates 0 one cycle later; enable restored → 25-cycle dead interval, then gates follow commands.
- **Fault latch (DEADTIME_FAULT_LATCH_EN):** fault_n pulsed low for 1 cycle → fault_flag=1 and all gates 0 within 3 cycles, held until fault_clr=1 with fault_n=1. fault_clr held while fault_n=0 → fault_flag stays 1.
- **Async reset mid-operation:** reset asserted during HI_ON → gates 0 without waiting for a clock edge. Random Va/Vb/Vc for 10⁵ cycles → hi&lo never 1 on any phase.
